// File: rtl/div_pkg.sv
// Shared state encoding, widths and result constants for the iterative divider.
package div_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } DivState;

   localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;

   // An operand only counts as negative when the divide is two's-complement.
   function automatic logic isNegative(input logic signedOp, input logic msb);
      return signedOp & msb;
   endfunction

endpackage

// File: rtl/negate32.sv
// Conditional two's-complement: passes the operand through or returns its negation.
module negate32
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] operand,
   input  logic             negate,
   output logic [WIDTH-1:0] result
);

   assign result = negate ? (~operand + WIDTH'(1)) : operand;

endmodule

// File: rtl/div32_iter.sv
// Iterative restoring divider, one quotient bit per clock, signed or unsigned,
// with a start/busy/done handshake toward the pipeline stall logic.
module div32_iter
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   DivState          state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] remReg;
   logic [WIDTH-1:0] quoReg;
   logic [WIDTH-1:0] divMag;
   logic             negQuo;
   logic             negRem;

   logic             dividendNeg;
   logic             divisorNeg;
   logic [WIDTH-1:0] dividendMag;
   logic [WIDTH-1:0] divisorMag;
   logic [WIDTH-1:0] quoFixed;
   logic [WIDTH-1:0] remFixed;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             trialOk;
   logic [WIDTH-1:0] nextRem;
   logic [WIDTH-1:0] nextQuo;

   assign dividendNeg = isNegative(is_signed, dividend[WIDTH-1]);
   assign divisorNeg  = isNegative(is_signed, divisor[WIDTH-1]);

   negate32 #(.WIDTH(WIDTH)) dividendAbs (
      .operand (dividend),
      .negate  (dividendNeg),
      .result  (dividendMag)
   );

   negate32 #(.WIDTH(WIDTH)) divisorAbs (
      .operand (divisor),
      .negate  (divisorNeg),
      .result  (divisorMag)
   );

   negate32 #(.WIDTH(WIDTH)) quotientFix (
      .operand (quoReg),
      .negate  (negQuo),
      .result  (quoFixed)
   );

   negate32 #(.WIDTH(WIDTH)) remainderFix (
      .operand (remReg),
      .negate  (negRem),
      .result  (remFixed)
   );

   // One restoring step. The partial remainder is always below the divisor, so
   // a set top bit after the shift guarantees the subtract succeeds; otherwise
   // the borrow of the low WIDTH+1-bit subtract decides.
   always_comb begin
      shifted = {remReg, quoReg[WIDTH-1]};
      trial   = {1'b0, shifted[WIDTH-1:0]} - {1'b0, divMag};
      trialOk = shifted[WIDTH] | ~trial[WIDTH];
      nextRem = trialOk ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      nextQuo = {quoReg[WIDTH-2:0], trialOk};
   end

   // Control FSM with registered handshake and result outputs. Results only
   // change on entry to DONE, so they hold steady through the next divide.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         remReg      <= '0;
         quoReg      <= '0;
         divMag      <= '0;
         negQuo      <= 1'b0;
         negRem      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  remReg <= '0;
                  quoReg <= dividendMag;
                  divMag <= divisorMag;
                  negQuo <= dividendNeg ^ divisorNeg;
                  negRem <= dividendNeg;
                  count  <= CNT_W'(WIDTH);
                  busy   <= 1'b1;
                  if (divisor == '0) begin
                     quotient    <= WIDTH'(DIV0_QUOT);
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               remReg <= nextRem;
               quoReg <= nextQuo;
               count  <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  state <= FIXUP;
               end
            end
            FIXUP: begin
               quotient    <= quoFixed;
               remainder   <= remFixed;
               div_by_zero <= 1'b0;
               done        <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div32_iter.sv
// Self-checking bench for div32_iter: table vectors, random vectors against a
// reference model, and hand sequences for ignored start and mid-divide reset.
module tb_div32_iter;

   typedef struct {
      logic        isSigned;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
   } Vec;

   logic        clock;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int          passCount;
   int          totalChecks;
   Vec          sbQueue[$];
   Vec          vectors[13];
   logic [31:0] heldQ;
   logic [31:0] heldR;
   logic        heldZ;

   div32_iter dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      totalChecks++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      else
         passCount++;
   endtask

   function automatic Vec makeVec(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] q, input logic [31:0] r, input logic z);
      Vec v;
      v.isSigned = s; v.a = a; v.b = b; v.q = q; v.r = r; v.z = z;
      return v;
   endfunction

   // Reference model using the language's own division operators.
   function automatic Vec model(input logic s, input logic [31:0] a, input logic [31:0] b);
      Vec v;
      v = makeVec(s, a, b, 32'h0, 32'h0, 1'b0);
      if (b == 32'h0) begin
         v.q = 32'hFFFFFFFF; v.r = a; v.z = 1'b1;
      end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
         v.q = 32'h80000000; v.r = 32'h0;
      end else if (s) begin
         v.q = 32'($signed(a) / $signed(b));
         v.r = 32'($signed(a) % $signed(b));
      end else begin
         v.q = a / b;
         v.r = a % b;
      end
      return v;
   endfunction

   task automatic applyStimulus(input Vec v);
      is_signed = v.isSigned;
      dividend  = v.a;
      divisor   = v.b;
      start     = 1'b1;
      sbQueue.push_back(v);
      tick();
      start     = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      is_signed = 1'($urandom);
      heldQ     = quotient;
      heldR     = remainder;
      heldZ     = div_by_zero;
   endtask

   // Waits (bounded) for done; elapsed = cycles already spent after acceptance.
   task automatic waitDone(input int elapsed);
      int n;
      int notBusy;
      int changed;
      bit seen;
      Vec e;
      n = elapsed; notBusy = 0; changed = 0; seen = 0;
      while (n < 60 && !seen) begin
         if (done) begin
            seen = 1;
         end else begin
            if (!busy) notBusy++;
            if (quotient !== heldQ || remainder !== heldR || div_by_zero !== heldZ) changed++;
            tick();
            n++;
         end
      end
      checkOutput("done seen", 32'(seen), 32'd1);
      if (!seen) return;
      if (sbQueue.size() == 0) begin
         checkOutput("scoreboard nonempty", 32'd0, 32'd1);
         return;
      end
      e = sbQueue.pop_front();
      checkOutput("latency", 32'(n + 1), (e.b == 32'h0) ? 32'd1 : 32'd34);
      checkOutput("busy during run", 32'(notBusy), 32'd0);
      checkOutput("results held", 32'(changed), 32'd0);
      checkOutput("busy at done", 32'(busy), 32'd1);
      checkOutput("quotient", quotient, e.q);
      checkOutput("remainder", remainder, e.r);
      checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.z));
      tick();
      checkOutput("done one cycle", 32'(done), 32'd0);
      checkOutput("busy after done", 32'(busy), 32'd0);
   endtask

   initial begin
      int extra;
      Vec v;
      logic [31:0] ra;
      logic [31:0] rb;
      passCount   = 0;
      totalChecks = 0;
      reset       = 1'b1;
      start       = 1'b0;
      is_signed   = 1'b0;
      dividend    = 32'h0;
      divisor     = 32'h0;
      heldQ       = 32'h0;
      heldR       = 32'h0;
      heldZ       = 1'b0;

      vectors[0]  = makeVec(1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0);
      vectors[1]  = makeVec(1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0);
      vectors[2]  = makeVec(1'b1, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0);
      vectors[3]  = makeVec(1'b0, 32'h12345678,  32'h0,         32'hFFFFFFFF,  32'h12345678,  1'b1);
      vectors[4]  = makeVec(1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h0,         1'b0);
      vectors[5]  = makeVec(1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'h0,         1'b0);
      vectors[6]  = makeVec(1'b0, 32'hFFFFFFFF,  32'h10,        32'h0FFFFFFF,  32'hF,         1'b0);
      vectors[7]  = makeVec(1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0);
      vectors[8]  = makeVec(1'b1, 32'hFFFFFF9C,  32'h0,         32'hFFFFFFFF,  32'hFFFFFF9C,  1'b1);
      vectors[9]  = makeVec(1'b0, 32'd5,         32'd9,         32'd0,         32'd5,         1'b0);
      vectors[10] = makeVec(1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h0,         32'h80000000,  1'b0);
      vectors[11] = makeVec(1'b1, 32'd7,         32'd7,         32'd1,         32'd0,         1'b0);
      vectors[12] = makeVec(1'b0, 32'hFFFFFFFE,  32'hFFFFFFFF,  32'h0,         32'hFFFFFFFE,  1'b0);

      $display("[TB] reset state");
      tick(); tick(); tick();
      reset = 1'b0;
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset quotient", quotient, 32'h0);
      checkOutput("reset remainder", remainder, 32'h0);
      checkOutput("reset div_by_zero", 32'(div_by_zero), 32'd0);

      $display("[TB] table vectors, back-to-back");
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vectors[i]);
         waitDone(0);
      end

      $display("[TB] random vectors");
      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'h0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            3:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
            default: rb = $urandom >> $urandom_range(0, 28);
         endcase
         v = model(1'($urandom), ra, rb);
         applyStimulus(v);
         waitDone(0);
      end

      $display("[TB] start during busy is ignored");
      applyStimulus(makeVec(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0));
      repeat (4) tick();
      is_signed = 1'b1; dividend = 32'd50; divisor = 32'd0; start = 1'b1;
      tick();
      start = 1'b0;
      waitDone(5);
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) extra++;
         tick();
      end
      checkOutput("no queued done", 32'(extra), 32'd0);

      $display("[TB] reset mid-divide");
      applyStimulus(makeVec(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0));
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sbQueue.delete();
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort done", 32'(done), 32'd0);
      checkOutput("abort quotient", quotient, 32'h0);
      checkOutput("abort remainder", remainder, 32'h0);
      checkOutput("abort div_by_zero", 32'(div_by_zero), 32'd0);
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy) extra++;
         tick();
      end
      checkOutput("no done after abort", 32'(extra), 32'd0);
      applyStimulus(makeVec(1'b1, 32'hFFFFFC18, 32'd3, 32'hFFFFFEB3, 32'hFFFFFFFF, 1'b0));
      waitDone(0);

      $display("%0d/%0d checks passed", passCount, totalChecks);
      $finish;
   end

endmodule
